// File: rtl/debounce_event_bank.sv
// rtl/debounce_event_bank.sv - N_CH-channel synchronizer/debouncer with press, long-press and per-channel output modes.
// Optional build macro LONG_PRESS_EN enables hold counters, long_pulse and the LONG mode.
module debounce_event_bank #(
    parameter int N_CH        = 6,
    parameter int DB_CYCLES   = 50000,
    parameter int LONG_CYCLES = 250000000
) (
    input  logic              clk,
    input  logic              reset_tmp,
    input  logic [N_CH-1:0]   raw_in,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   db_level,
    output logic [N_CH-1:0]   ch_out,
    output logic [N_CH-1:0]   press_pulse,
    output logic [N_CH-1:0]   long_pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    localparam logic [1:0] M_LEVEL  = 2'b00;
    localparam logic [1:0] M_TOGGLE = 2'b01;
    localparam logic [1:0] M_PULSE  = 2'b10;
    localparam logic [1:0] M_LONG   = 2'b11;

    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic [N_CH-1:0]   db_dly;
    logic [N_CH-1:0]   fall_pulse;
    logic [2*N_CH-1:0] mode_q;

    // Shared per-bit pipeline: synchronizer, previous debounced level and edge strobes.
    always_ff @(posedge clk or negedge reset_tmp) begin
        if (!reset_tmp) begin
            sync1       <= '0;
            sync2       <= '0;
            db_dly      <= '0;
            press_pulse <= '0;
            fall_pulse  <= '0;
            mode_q      <= '0;
        end else begin
            sync1       <= raw_in;
            sync2       <= sync1;
            db_dly      <= db_level;
            press_pulse <= db_level & ~db_dly;
            fall_pulse  <= ~db_level & db_dly;
            mode_q      <= mode;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          db_r;
        logic          tog;
        logic          tog_ev;
        logic          ch_r;
        logic [1:0]    mode_sel;
        logic          mode_chg;

        assign mode_sel = mode[2*i +: 2];
        assign mode_chg = (mode_sel != mode_q[2*i +: 2]);

        always_ff @(posedge clk or negedge reset_tmp) begin
            if (!reset_tmp) begin
                cnt  <= '0;
                db_r <= 1'b0;
            end else if (sync2[i] != db_r) begin
                if (cnt == DB_LAST) begin
                    db_r <= ~db_r;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign db_level[i] = db_r;

`ifdef LONG_PRESS_EN
        localparam int HW = $clog2(LONG_CYCLES + 1);
        localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
        localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

        logic [HW-1:0] hold;
        logic          long_r;

        // Hold saturates at LONG_CYCLES, so the strobe can only fire once per press.
        always_ff @(posedge clk or negedge reset_tmp) begin
            if (!reset_tmp) begin
                hold   <= '0;
                long_r <= 1'b0;
            end else begin
                long_r <= db_r && (hold == LONG_LAST);
                if (!db_r) begin
                    hold <= '0;
                end else if (hold != LONG_MAX) begin
                    hold <= hold + 1'b1;
                end
            end
        end

        assign long_pulse[i] = long_r;
        assign tog_ev = ((mode_sel == M_TOGGLE) && fall_pulse[i]) ||
                        ((mode_sel == M_LONG) && long_r);
`else
        assign long_pulse[i] = 1'b0;
        assign tog_ev = ((mode_sel == M_TOGGLE) || (mode_sel == M_LONG)) && fall_pulse[i];
`endif

        // Clear and mode change both override a coincident toggle event.
        always_ff @(posedge clk or negedge reset_tmp) begin
            if (!reset_tmp) begin
                tog <= 1'b0;
            end else if (clr[i] || mode_chg) begin
                tog <= 1'b0;
            end else if (tog_ev) begin
                tog <= ~tog;
            end
        end

        always_comb begin
            ch_r = 1'b0;
            case (mode_sel)
                M_LEVEL:  ch_r = db_dly[i];
                M_PULSE:  ch_r = press_pulse[i];
                default:  ch_r = tog;
            endcase
        end

        assign ch_out[i] = ch_r;
    end

endmodule

// File: tb/tb_debounce_event_bank.sv
// tb/tb_debounce_event_bank.sv - directed and randomized bench for debounce_event_bank against a window-based reference model.
module tb_debounce_event_bank;

    localparam int N  = 4;
    localparam int DB = 5;
    localparam int LG = 20;

    logic         clk = 1'b0;
    logic         reset_tmp;
    logic [N-1:0] raw_in;
    logic [2*N-1:0] mode;
    logic [N-1:0] clr;
    logic [N-1:0] db_level;
    logic [N-1:0] ch_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] long_pulse;

    always #5 clk = ~clk;

    debounce_event_bank #(.N_CH(N), .DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
        .clk(clk), .reset_tmp(reset_tmp), .raw_in(raw_in), .mode(mode), .clr(clr),
        .db_level(db_level), .ch_out(ch_out), .press_pulse(press_pulse), .long_pulse(long_pulse)
    );

    int checks = 0;
    int errors = 0;
    int n_long = 0;

`ifdef LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    // Reference: a level is accepted once the last DB synchronized samples all disagree with it.
    logic [N-1:0]   m_s1, m_s2, m_db, m_dbd, m_press, m_fall, m_long, m_tog;
    logic [2*N-1:0] m_mq;
    logic [DB-1:0]  m_win [N];
    int             m_hold [N];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_dbd = '0;
        m_press = '0; m_fall = '0; m_long = '0; m_tog = '0; m_mq = '0;
        for (int c = 0; c < N; c++) begin
            m_win[c]  = '0;
            m_hold[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] n_db, n_press, n_fall, n_long, n_tog;
        for (int c = 0; c < N; c++) begin
            logic [DB-1:0] w;
            logic [1:0]    md;
            bit            ev;
            w = {m_win[c][DB-2:0], m_s2[c]};
            m_win[c] = w;
            n_db[c]    = (w == {DB{~m_db[c]}}) ? ~m_db[c] : m_db[c];
            n_press[c] = m_db[c] & ~m_dbd[c];
            n_fall[c]  = ~m_db[c] & m_dbd[c];
            n_long[c]  = LP && m_db[c] && (m_hold[c] + 1 == LG);
            md = mode[2*c +: 2];
            if (LP)
                ev = (md == 2'b01 && m_fall[c]) || (md == 2'b11 && m_long[c]);
            else
                ev = (md == 2'b01 || md == 2'b11) && m_fall[c];
            if (clr[c] || md != m_mq[2*c +: 2]) n_tog[c] = 1'b0;
            else if (ev)                        n_tog[c] = ~m_tog[c];
            else                                n_tog[c] = m_tog[c];
            m_hold[c] = m_db[c] ? m_hold[c] + 1 : 0;
        end
        m_dbd = m_db; m_db = n_db; m_press = n_press; m_fall = n_fall;
        m_long = n_long; m_tog = n_tog; m_mq = mode;
        m_s2 = m_s1; m_s1 = raw_in;
    endtask

    function automatic logic [N-1:0] exp_ch_out();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) begin
            case (mode[2*c +: 2])
                2'b00:   r[c] = m_dbd[c];
                2'b10:   r[c] = m_press[c];
                default: r[c] = m_tog[c];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_tmp) model_step();
        #1;
        if (long_pulse[2]) n_long++;
        chk("db_level", db_level, m_db);
        chk("press_pulse", press_pulse, m_press);
        chk("long_pulse", long_pulse, m_long);
        chk("ch_out", ch_out, exp_ch_out());
    endtask

    task automatic hold_raw(input int c, input bit v, input int n);
        raw_in[c] = v;
        repeat (n) tick();
    endtask

    task automatic async_reset();
        reset_tmp = 1'b0;
        #1;
        chk("rst_db", db_level, '0);
        chk("rst_press", press_pulse, '0);
        chk("rst_long", long_pulse, '0);
        chk("rst_ch_out", ch_out, '0);
        model_reset();
        repeat (2) tick();
        #1 reset_tmp = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset_tmp = 1'b0;
        raw_in = 4'hF;
        mode = '0;
        clr = '0;
        model_reset();

        // 1: reset with all pins high, then release
        #2;
        async_reset();
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 6) chk("t1_db_early", db_level, 4'h0);
            if (k == 7) chk("t1_db_rise", db_level, 4'hF);
            if (k == 8) chk("t1_press", press_pulse, 4'hF);
            if (k == 9) chk("t1_press_end", press_pulse, 4'h0);
        end

        // 2: bounce on ch0
        raw_in = 4'h0;
        repeat (12) tick();
        hold_raw(0, 1'b1, 3); hold_raw(0, 1'b0, 3);
        hold_raw(0, 1'b1, 3); hold_raw(0, 1'b0, 3);
        raw_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) chk("t2_db0_early", {3'b0, db_level[0]}, 4'h0);
            if (k == 7) chk("t2_db0_rise", {3'b0, db_level[0]}, 4'h1);
        end

        // 3: TOGGLE on ch1 flips on release only
        mode = 8'b00_00_01_00;
        tick();
        hold_raw(1, 1'b1, 10);
        chk("t3_no_press_toggle", {3'b0, ch_out[1]}, 4'h0);
        hold_raw(1, 1'b0, 15);
        chk("t3_first_release", {3'b0, ch_out[1]}, 4'h1);
        hold_raw(1, 1'b1, 10);
        hold_raw(1, 1'b0, 15);
        chk("t3_second_release", {3'b0, ch_out[1]}, 4'h0);

        // 4: LONG on ch2
        mode = 8'b00_11_01_00;
        tick();
        n_long = 0;
        hold_raw(2, 1'b1, 10);
        hold_raw(2, 1'b0, 15);
        chk("t4_short_ch_out", {3'b0, ch_out[2]}, LP ? 4'h0 : 4'h1);
        hold_raw(2, 1'b1, 30);
        hold_raw(2, 1'b0, 15);
        chk("t4_long_count", 4'(n_long), LP ? 4'h1 : 4'h0);
        chk("t4_long_ch_out", {3'b0, ch_out[2]}, LP ? 4'h1 : 4'h0);

        // 5: clr coinciding with the toggle event, then mode change clears
        hold_raw(1, 1'b1, 10);
        raw_in[1] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = m_fall[1];
        end
        chk("t5_fall_seen", {3'b0, found}, 4'h1);
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        repeat (3) tick();
        chk("t5_clr_wins", {3'b0, ch_out[1]}, 4'h0);
        hold_raw(1, 1'b1, 10);
        hold_raw(1, 1'b0, 15);
        chk("t5_toggled", {3'b0, ch_out[1]}, 4'h1);
        mode[3:2] = 2'b00;
        tick();
        mode[3:2] = 2'b01;
        tick();
        chk("t5_mode_clear", {3'b0, ch_out[1]}, 4'h0);

        // 6: async reset mid-hold on ch2
        raw_in[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = (m_hold[2] == 15);
        end
        chk("t6_hold15", {3'b0, found}, 4'h1);
        async_reset();
        n_long = 0;
        repeat (30) tick();
        chk("t6_long_restart", 4'(n_long), LP ? 4'h1 : 4'h0);
        chk("t6_ch2", {3'b0, ch_out[2]}, LP ? 4'h1 : 4'h0);

        // randomized soak
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) raw_in[c] = ~raw_in[c];
            end
            if ($urandom_range(0, 199) == 0) mode = 8'($urandom);
            clr = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
